// File: rtl/fetch_stage_pkg.sv
// Shared encodings and helpers for the instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StReset   = 2'd0,
        StFetch   = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC buffer that catches memory data while decode is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= instr_in;
            pc_q    <= pc_in;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the imem req/ack handshake and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  disc_addr_q, disc_addr_d;

    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  opc_q, opc_d;
    logic [31:0]  opc4_q, opc4_d;

    logic         skid_valid, skid_load, skid_drain;
    logic [31:0]  skid_instr, skid_pc;
    logic         fetch_ack, out_free;

    assign imem_req  = (state_q != StReset) && !skid_valid;
    assign fetch_ack = imem_req && imem_ack && (state_q == StFetch);
    assign out_free  = !valid_q || !stall;

    always_comb begin
        case (state_q)
            StFetch:   imem_addr = pc_q;
            StDiscard: imem_addr = disc_addr_q;
            default:   imem_addr = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;

        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (fetch_ack) begin
            pc_d = pc_q + 32'd4;
        end

        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                // An unacked request cannot be withdrawn; remember it and swallow its data.
                if (redirect_valid && imem_req && !imem_ack) begin
                    disc_addr_d = pc_q;
                    state_d     = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_ack) state_d = StFetch;
            end
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        opc4_d     = opc4_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;

        if (redirect_valid) begin
            valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                valid_d    = 1'b1;
                instr_d    = skid_instr;
                opc_d      = skid_pc;
                opc4_d     = skid_pc + 32'd4;
                skid_drain = 1'b1;
            end else if (fetch_ack) begin
                valid_d = 1'b1;
                instr_d = imem_rdata;
                opc_d   = pc_q;
                opc4_d  = pc_q + 32'd4;
            end else begin
                valid_d = 1'b0;
            end
        end else if (fetch_ack) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StReset;
            pc_q        <= RESET_PC;
            disc_addr_q <= '0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            opc_q       <= '0;
            opc4_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            opc_q       <= opc_d;
            opc4_q      <= opc4_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .drain    (skid_drain),
        .flush    (redirect_valid),
        .instr_in (imem_rdata),
        .pc_in    (pc_q),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    assign instr_valid  = valid_q;
    assign instr_out    = instr_q;
    assign pc_out       = opc_q;
    assign pc_plus4_out = opc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random stalls, redirects and memory latency.
module tb_fetch_stage;

    localparam logic [31:0] RstPc = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr_out, pc_out, pc_plus4_out;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RstPc)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pc_plus4_out   (pc_plus4_out)
    );

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: instruction word is the address inverted; random or fixed latency.
    int unsigned wait_cnt = 0;
    int unsigned lat_max  = 0;
    bit          lat_fixed = 1'b0;

    function automatic int unsigned pick_lat();
        if (lat_fixed || lat_max == 0) return lat_max;
        return $urandom_range(lat_max, 0);
    endfunction

    assign imem_ack   = imem_req && (wait_cnt == 0);
    assign imem_rdata = imem_addr ^ 32'hFFFF_FFFF;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= pick_lat();
        else if (imem_req && imem_ack) wait_cnt <= pick_lat();
        else if (imem_req && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
    end

    // Reference stream: program order from the last reset/redirect target, stepping by 4.
    logic [31:0] exp_q[$];

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(pc);
    endtask

    bit          mon_en = 1'b0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr;
    int          idle = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_pending = 1'b0;
            idle = 0;
        end else if (mon_en) begin
            if (imem_req) check("addr_align", imem_addr & 32'd3, 32'd0);
            if (prev_pending) begin
                check("req_hold", {31'd0, imem_req}, 32'd1);
                check("addr_hold", imem_addr, prev_addr);
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;

            if (instr_valid && !stall && !redirect_valid) begin
                idle = 0;
                consumed++;
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", pc_out, e);
                    check("sb_instr", instr_out, e ^ 32'hFFFF_FFFF);
                    check("sb_pc_plus4", pc_plus4_out, e + 32'd4);
                    if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
                end
            end else begin
                idle++;
                if (idle > 60) begin
                    check("progress", 32'd0, 32'd1);
                    idle = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        start_stream(target & 32'hFFFF_FFFC);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instr_out, 32'd0);
        check({tag, "_pc"}, pc_out, 32'd0);
        check({tag, "_pc4"}, pc_plus4_out, 32'd0);
    endtask

    initial begin
        int          c0;
        logic [31:0] held, old_addr;
        bit          found;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) tick();
        check_outputs_reset("reset");

        // Zero-wait memory: one instruction per cycle, latency 1.
        start_stream(RstPc);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RstPc);
        check("first_valid_early", {31'd0, instr_valid}, 32'd0);
        tick();
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_pc", pc_out, RstPc);
        check("addr_seq1", imem_addr, RstPc + 32'd4);
        tick();
        check("addr_seq2", imem_addr, RstPc + 32'd8);
        c0 = consumed;
        repeat (8) tick();
        check("throughput", consumed - c0, 32'd8);

        // Stall three cycles: output holds, next word goes to skid, fetch pauses.
        held = pc_out;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_pc", pc_out, held);
            check("stall_req_low", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("skid_drain_pc", pc_out, held + 32'd4);
        check("refetch_addr", imem_addr, held + 32'd8);
        tick();
        check("after_skid_pc", pc_out, held + 32'd8);

        // Redirect while stalled with skid full: everything squashed.
        stall = 1'b1;
        repeat (2) tick();
        redirect(32'h0000_0203);
        stall = 1'b0;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid_clr", {31'd0, instr_valid}, 32'd0);
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0200);
        tick();
        check("redir_pc", pc_out, 32'h0000_0200);

        // Redirect to the top of the address space: pc+4 wraps.
        redirect(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4_out, 32'd0);
        check("wrap_addr", imem_addr, 32'd0);

        // Slow memory: redirect while a request is outstanding.
        lat_max = 3; lat_fixed = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_req && !imem_ack) found = 1'b1;
        end
        check("pending_found", {31'd0, found}, 32'd1);
        old_addr = imem_addr;
        redirect(32'h0000_0103);
        tick();
        redirect_valid = 1'b0;
        check("disc_req", {31'd0, imem_req}, 32'd1);
        check("disc_addr", imem_addr, old_addr);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 32'h0000_0100) found = 1'b1;
            else tick();
        end
        check("disc_new_addr", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (instr_valid) found = 1'b1;
        end
        check("disc_first_valid", {31'd0, found}, 32'd1);
        check("disc_first_pc", pc_out, 32'h0000_0100);

        // Reset in the middle of a stall with skid full.
        lat_max = 0; lat_fixed = 1'b0;
        repeat (6) tick();
        stall = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check_outputs_reset("midrst");
        tick();
        rst = 1'b0;
        stall = 1'b0;
        start_stream(RstPc);
        tick();
        check("midrst_req", {31'd0, imem_req}, 32'd1);
        check("midrst_addr", imem_addr, RstPc);

        // Random traffic.
        lat_max = 3;
        c0 = consumed;
        for (int i = 0; i < 2000; i++) begin
            tick();
            stall = ($urandom_range(9, 0) < 3);
            if ($urandom_range(19, 0) == 0) begin
                if ($urandom_range(3, 0) == 0) redirect(32'hFFFF_FFF0 + $urandom_range(15, 0));
                else redirect($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        repeat (10) tick();
        check("random_progress", {31'd0, (consumed - c0) > 200}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
